// File: rtl/eth_defs_pkg.sv
// Shared Ethernet receive definitions: framing nibbles, CRC-32 constants, FSM encodings
// and the byte-wide reflected CRC-32 update used by the receive path and the FCS generator.
package eth_defs;

  localparam logic [3:0]  ETH_PREAMBLE_NIBBLE = 4'h5;
  localparam logic [3:0]  ETH_SFD_NIBBLE      = 4'hD;
  localparam logic [31:0] CRC32_POLY_REFL     = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT          = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE       = 32'hDEBB20E3;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PREAMBLE = 2'd1;
  localparam logic [1:0] ST_DATA     = 2'd2;
  localparam logic [1:0] ST_DROP     = 2'd3;

  // One byte of reflected CRC-32, LSB first, no final inversion.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/ethernet_receive_data_crc.sv
// Combinational CRC-32 next-state for one byte; shared with the frame transmitter's FCS path.
module crc32_byte_next
  import eth_defs::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_crc
);

  assign o_crc = crc32_byte(i_crc, i_byte);

endmodule

// File: rtl/ethernet_receive_data.sv
// MII receive path: strips preamble/SFD, packs nibbles into bytes, writes the frame into RAM
// from address 0 and reports length plus good/bad status (CRC, RX_ER, parity of nibbles, size).
module ethernet_receive_data
  import eth_defs::*;
#(
  parameter int ADDR_W       = 11,
  parameter int MAX_FRAME    = 1518,
  parameter int MIN_FRAME    = 64,
  parameter int MIN_PREAMBLE = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        ETH_RX_DATA,
  input  logic              ETH_RX_DV,
  input  logic              ETH_RX_ER,
  input  logic              rx_enable,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic              ram_wr,
  output logic              frame_done,
  output logic              frame_ok,
  output logic [ADDR_W-1:0] frame_len,
  output logic              rx_busy
);

  logic [1:0]        r_state;
  logic [2:0]        r_pre_cnt;
  logic              r_phase;
  logic [3:0]        r_lo_nib;
  logic [ADDR_W-1:0] r_idx;
  logic [31:0]       r_crc;
  logic              r_err;
  logic              r_ovf;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [7:0]        r_ram_data;
  logic              r_ram_wr;
  logic              r_frame_done;
  logic              r_frame_ok;
  logic [ADDR_W-1:0] r_frame_len;
  logic              r_busy;

  logic [1:0]  w_state_next;
  logic [7:0]  w_byte;
  logic [31:0] w_crc_next;

  assign w_byte = {ETH_RX_DATA, r_lo_nib};

  crc32_byte_next u_crc (
    .i_crc  (r_crc),
    .i_byte (w_byte),
    .o_crc  (w_crc_next)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (ETH_RX_DV) begin
          if (rx_enable && (ETH_RX_DATA == ETH_PREAMBLE_NIBBLE)) w_state_next = ST_PREAMBLE;
          else                                                 w_state_next = ST_DROP;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_PREAMBLE: begin
        if (!ETH_RX_DV)                                  w_state_next = ST_IDLE;
        else if (ETH_RX_ER)                              w_state_next = ST_DROP;
        else if (ETH_RX_DATA == ETH_PREAMBLE_NIBBLE)     w_state_next = ST_PREAMBLE;
        else if ((ETH_RX_DATA == ETH_SFD_NIBBLE) &&
                 (r_pre_cnt >= 3'(MIN_PREAMBLE)))        w_state_next = ST_DATA;
        else                                             w_state_next = ST_DROP;
      end
      ST_DATA: begin
        if (!ETH_RX_DV) w_state_next = ST_IDLE;
        else            w_state_next = ST_DATA;
      end
      ST_DROP: begin
        if (!ETH_RX_DV) w_state_next = ST_IDLE;
        else            w_state_next = ST_DROP;
      end
      default: w_state_next = ST_DROP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_DROP;
      r_pre_cnt    <= 3'd0;
      r_phase      <= 1'b0;
      r_lo_nib     <= 4'h0;
      r_idx        <= '0;
      r_crc        <= CRC32_INIT;
      r_err        <= 1'b0;
      r_ovf        <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_data   <= 8'h00;
      r_ram_wr     <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_ok   <= 1'b0;
      r_frame_len  <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_busy       <= (w_state_next == ST_PREAMBLE) || (w_state_next == ST_DATA);
      r_ram_wr     <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: r_pre_cnt <= 3'd1;
        ST_PREAMBLE: begin
          if ((ETH_RX_DATA == ETH_PREAMBLE_NIBBLE) && (r_pre_cnt != 3'd7))
            r_pre_cnt <= r_pre_cnt + 3'd1;
          if (w_state_next == ST_DATA) begin
            r_frame_ok  <= 1'b0;
            r_frame_len <= '0;
            r_idx       <= '0;
            r_crc       <= CRC32_INIT;
            r_err       <= 1'b0;
            r_ovf       <= 1'b0;
            r_phase     <= 1'b0;
          end
        end
        ST_DATA: begin
          if (ETH_RX_DV) begin
            if (ETH_RX_ER) r_err <= 1'b1;
            if (!r_phase) begin
              r_lo_nib <= ETH_RX_DATA;
              r_phase  <= 1'b1;
            end else begin
              r_phase <= 1'b0;
              r_crc   <= w_crc_next;
              // Past the RAM limit the byte still feeds the CRC but is not stored.
              if (r_idx == ADDR_W'(MAX_FRAME)) begin
                r_ovf <= 1'b1;
              end else begin
                r_ram_wr   <= 1'b1;
                r_ram_addr <= r_idx;
                r_ram_data <= w_byte;
                r_idx      <= r_idx + 1'b1;
              end
            end
          end else begin
            r_frame_done <= 1'b1;
            r_frame_len  <= r_idx;
            r_frame_ok   <= (r_crc == CRC32_RESIDUE) && !r_err && !r_phase && !r_ovf &&
                            (r_idx >= ADDR_W'(MIN_FRAME)) && (r_idx <= ADDR_W'(MAX_FRAME));
          end
        end
        default: r_pre_cnt <= r_pre_cnt;
      endcase
    end
  end

  assign ram_addr   = r_ram_addr;
  assign ram_data   = r_ram_data;
  assign ram_wr     = r_ram_wr;
  assign frame_done = r_frame_done;
  assign frame_ok   = r_frame_ok;
  assign frame_len  = r_frame_len;
  assign rx_busy    = r_busy;

endmodule

// File: tb/tb_ethernet_receive_data.sv
// Directed bench for ethernet_receive_data: builds frames with a locally computed FCS,
// drives MII nibbles and checks RAM writes, frame_done, frame_ok and frame_len.
module tb_ethernet_receive_data;

  logic        clk = 1'b0;
  logic        reset, dv, er, en;
  logic [3:0]  rxd;
  logic [10:0] ram_addr, frame_len;
  logic [7:0]  ram_data;
  logic        ram_wr, frame_done, frame_ok, rx_busy;

  always #5 clk = ~clk;

  ethernet_receive_data dut (
    .clk(clk), .reset(reset), .ETH_RX_DATA(rxd), .ETH_RX_DV(dv), .ETH_RX_ER(er),
    .rx_enable(en), .ram_addr(ram_addr), .ram_data(ram_data), .ram_wr(ram_wr),
    .frame_done(frame_done), .frame_ok(frame_ok), .frame_len(frame_len), .rx_busy(rx_busy)
  );

  logic [7:0] frame [0:1699];
  int flen;
  int n_wr, n_done, addr_err, data_err, max_addr, ok_at_done, len_at_done;
  int n_checks = 0, n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Bit-serial reflected CRC-32 reference.
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int b = 0; b < 8; b++) r = (r[0] ^ d[b]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic build(input int payload_len);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < payload_len; i++) begin
      frame[i] = 8'((i * 37 + 11) ^ (i >> 3));
      c = crc_upd(c, frame[i]);
    end
    c = ~c;
    frame[payload_len]     = c[7:0];
    frame[payload_len + 1] = c[15:8];
    frame[payload_len + 2] = c[23:16];
    frame[payload_len + 3] = c[31:24];
    flen = payload_len + 4;
  endtask

  task automatic clr();
    n_wr = 0; n_done = 0; addr_err = 0; data_err = 0; max_addr = -1;
    ok_at_done = -1; len_at_done = -1;
  endtask

  task automatic drive(input logic v, input logic [3:0] d, input logic e, input logic r);
    @(posedge clk); #2;
    dv = v; rxd = d; er = e; reset = r;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wr"}, ram_wr, 0);
    chk({tag, "_done"}, frame_done, 0);
    chk({tag, "_ok"}, frame_ok, 0);
    chk({tag, "_len"}, frame_len, 0);
    chk({tag, "_busy"}, rx_busy, 0);
    chk({tag, "_addr"}, ram_addr, 0);
    chk({tag, "_data"}, ram_data, 0);
  endtask

  task automatic send(input int pre_n, input logic [3:0] sfd, input int er_byte,
                      input int rst_byte, input bit extra_nib, input logic ena);
    en = ena;
    for (int i = 0; i < pre_n; i++) drive(1'b1, 4'h5, 1'b0, 1'b1);
    drive(1'b1, sfd, 1'b0, 1'b1);
    for (int i = 0; i < flen; i++) begin
      drive(1'b1, frame[i][3:0], (i == er_byte), (i != rst_byte));
      @(posedge clk); #2;
      if (i == rst_byte) chk_zero("midrst");
      dv = 1'b1; rxd = frame[i][7:4]; er = 1'b0; reset = 1'b1;
    end
    if (extra_nib) drive(1'b1, 4'h3, 1'b0, 1'b1);
    drive(1'b0, 4'h0, 1'b0, 1'b1);
  endtask

  task automatic settle();
    for (int i = 0; i < 3; i++) @(posedge clk);
    #2;
  endtask

  task automatic chk_frame(input string tag, input int wr, input int done, input int ok, input int len);
    chk({tag, "_nwr"}, n_wr, wr);
    chk({tag, "_ndone"}, n_done, done);
    chk({tag, "_aseq"}, addr_err, 0);
    chk({tag, "_dat"}, data_err, 0);
    if (done == 1) begin
      chk({tag, "_ok"}, ok_at_done, ok);
      chk({tag, "_len"}, len_at_done, len);
    end
  endtask

  initial begin
    clr();
    forever begin
      @(negedge clk);
      if (ram_wr) begin
        if (int'(ram_addr) != n_wr) addr_err++;
        else if (int'(ram_addr) < flen && ram_data != frame[ram_addr]) data_err++;
        if (int'(ram_addr) > max_addr) max_addr = int'(ram_addr);
        n_wr++;
      end
      if (frame_done) begin
        n_done++;
        ok_at_done = frame_ok;
        len_at_done = frame_len;
      end
    end
  end

  initial begin
    reset = 1'b0; dv = 1'b0; er = 1'b0; en = 1'b1; rxd = 4'h0;
    flen = 0;
    repeat (3) @(posedge clk);
    #2;
    chk_zero("reset");
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    build(60); clr(); send(7, 4'hD, -1, -1, 1'b0, 1'b1); settle();
    chk_frame("good", 64, 1, 1, 64);
    chk("good_maxaddr", max_addr, 63);
    chk("good_okheld", frame_ok, 1);

    build(60); frame[10] = frame[10] ^ 8'h04;
    clr(); send(7, 4'hD, -1, -1, 1'b0, 1'b1); settle();
    chk_frame("bitflip", 64, 1, 0, 64);

    build(60); clr(); send(7, 4'hD, 30, -1, 1'b0, 1'b1); settle();
    chk_frame("rxer", 64, 1, 0, 64);

    build(36); clr(); send(7, 4'hD, -1, -1, 1'b0, 1'b1); settle();
    chk_frame("runt", 40, 1, 0, 40);

    build(1596); clr(); send(7, 4'hD, -1, -1, 1'b0, 1'b1); settle();
    chk_frame("ovf", 1518, 1, 0, 1518);
    chk("ovf_maxaddr", max_addr, 1517);

    build(60); clr(); send(7, 4'hD, -1, -1, 1'b1, 1'b1); settle();
    chk_frame("oddnib", 64, 1, 0, 64);

    build(60); clr(); send(7, 4'hD, -1, -1, 1'b0, 1'b0); settle();
    chk_frame("rxdis", 0, 0, 0, 0);
    clr(); send(7, 4'hD, -1, -1, 1'b0, 1'b1); settle();
    chk_frame("rxen", 64, 1, 1, 64);

    clr(); send(3, 4'hD, -1, -1, 1'b0, 1'b1); settle();
    chk_frame("shortpre", 0, 0, 0, 0);
    clr(); send(6, 4'h7, -1, -1, 1'b0, 1'b1); settle();
    chk_frame("badsfd", 0, 0, 0, 0);
    clr(); send(6, 4'hD, -1, -1, 1'b0, 1'b1); settle();
    chk_frame("minpre", 64, 1, 1, 64);

    build(60); clr(); send(7, 4'hD, -1, 20, 1'b0, 1'b1);
    chk_frame("aborted", 20, 0, 0, 0);
    clr(); send(7, 4'hD, -1, -1, 1'b0, 1'b1); settle();
    chk_frame("afterrst", 64, 1, 1, 64);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
